// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared fetch-side types and constants
package if_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'b0;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] adder1;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO with registered head, sync clear, simultaneous push/pop
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           push,
    input  fetch_entry_t                   data,
    input  logic                           pop,
    output fetch_entry_t                   head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH + 1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A push at full is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && !clear && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC sequencing, imem request/response tracking and IF/ID head; FETCH_PERF_EN adds perf counters
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int          DEPTH           = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            id_ld,
    output logic            if_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] adder1
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_bubble_cnt,
    output logic [31:0]     perf_squash_cnt
`endif
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;
    logic [OW-1:0]   out_next;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     inflight_live;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fire;
    logic            push;
    logic            pop;
    logic            room;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;

    // Reserve FIFO space for every live request so a response never finds the FIFO full.
    assign inflight_live = 32'(outstanding) - 32'(drop_cnt);
    assign room          = (32'(fifo_count) + inflight_live) < 32'(DEPTH);
    assign imem_req      = !rst && !branch_taken && (outstanding < MAX_OUT) && room;
    assign imem_addr     = pc;
    assign fire          = imem_req && imem_gnt;
    assign push          = imem_rvalid && (drop_cnt == '0) && !branch_taken;
    assign pop           = id_ld && !fifo_empty && !branch_taken;
    assign push_entry    = '{inst: imem_rdata, adder1: resp_pc + PC_STEP};

    always_comb begin
        out_next = outstanding;
        if (fire) begin
            out_next = out_next + OW'(1);
        end
        if (imem_rvalid) begin
            out_next = out_next - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_next;
            if (branch_taken) begin
                pc       <= branch_target;
                resp_pc  <= branch_target;
                drop_cnt <= out_next;
            end else begin
                if (fire) begin
                    pc <= pc + PC_STEP;
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_STEP;
                end
                if (imem_rvalid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OW'(1);
                end
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (branch_taken),
        .push  (push),
        .data  (push_entry),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign if_valid = !fifo_empty;
    assign inst     = fifo_empty ? NOP_INST : fifo_head.inst;
    assign adder1   = fifo_empty ? NOP_INST : fifo_head.adder1;

    no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

`ifdef FETCH_PERF_EN
    logic [32:0] squash_sum;

    assign squash_sum = {1'b0, perf_squash_cnt} + 33'(fifo_count) + 33'(inflight_live);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubble_cnt <= '0;
            perf_squash_cnt <= '0;
        end else begin
            if (id_ld && fifo_empty && (perf_bubble_cnt != '1)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
            if (branch_taken) begin
                perf_squash_cnt <= squash_sum[32] ? '1 : squash_sum[31:0];
            end
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized and directed bench for if_fetch_unit against a queue-level fetch model
module tb_if_fetch_unit;
    localparam int DEPTH = 2;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ld;
    logic        if_valid;
    logic [31:0] inst;
    logic [31:0] adder1;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_squash_cnt;
    longint      bub_m;
    longint      sq_m;
`endif

    typedef struct { logic [31:0] addr; bit live; } infl_t;
    typedef struct { logic [31:0] inst; logic [31:0] adder1; } ent_t;

    ent_t        fifo_q[$];
    infl_t       infl_q[$];
    logic [31:0] popped_q[$];
    logic [31:0] granted_q[$];
    logic [31:0] pc_m;
    int          tests = 0;
    int          fails = 0;
    logic        o_req;
    logic        o_valid;
    logic [31:0] o_addr;
    logic [31:0] o_inst;
    logic [31:0] o_adder1;

    if_fetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_ld         (id_ld),
        .if_valid      (if_valid),
        .inst          (inst),
        .adder1        (adder1)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_squash_cnt (perf_squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'sh0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        branch_taken = 1'b0; branch_target = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; id_ld = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_adder1", adder1, 32'h0);
        fifo_q.delete(); infl_q.delete(); popped_q.delete(); granted_q.delete();
        pc_m = 32'h0;
`ifdef FETCH_PERF_EN
        bub_m = 0; sq_m = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: drive inputs, compare against the model, advance the model, wait for the next negedge.
    task automatic step(input bit bt, input logic [31:0] tgt, input bit gnt, input bit rv_en, input bit ld);
        int    live_n;
        bit    rv;
        bit    e_req;
        bit    e_valid;
        ent_t  h;
        ent_t  e;
        infl_t r;
        live_n = 0;
        foreach (infl_q[i]) if (infl_q[i].live) live_n++;
        rv = rv_en && (infl_q.size() > 0);
        branch_taken = bt; branch_target = tgt; imem_gnt = gnt; id_ld = ld;
        imem_rvalid = rv;
        imem_rdata = rv ? mem_fn(infl_q[0].addr) : 32'hDEAD_BEEF;
        #1;
        e_req   = !bt && (infl_q.size() < MAXO) && (fifo_q.size() + live_n < DEPTH);
        e_valid = fifo_q.size() > 0;
        if (e_valid) h = fifo_q[0];
        else begin h.inst = 32'h0; h.adder1 = 32'h0; end
        o_req = imem_req; o_addr = imem_addr; o_valid = if_valid; o_inst = inst; o_adder1 = adder1;
        chk("req", 32'(o_req), 32'(e_req));
        chk("addr", o_addr, pc_m);
        chk("valid", 32'(o_valid), 32'(e_valid));
        chk("inst", o_inst, h.inst);
        chk("adder1", o_adder1, h.adder1);
`ifdef FETCH_PERF_EN
        chk("perf_bubble", perf_bubble_cnt, sat32(bub_m));
        chk("perf_squash", perf_squash_cnt, sat32(sq_m));
        if (ld && !e_valid) bub_m++;
        if (bt) sq_m += fifo_q.size() + live_n;
`endif
        if (o_req && gnt) granted_q.push_back(o_addr);
        if (ld && e_valid && !bt) begin
            popped_q.push_back(fifo_q[0].adder1);
            fifo_q.delete(0);
        end
        if (rv) begin
            r = infl_q.pop_front();
            if (r.live && !bt) begin
                e.inst = mem_fn(r.addr);
                e.adder1 = r.addr + 32'd4;
                fifo_q.push_back(e);
            end
        end
        if (e_req && gnt) begin
            r.addr = pc_m; r.live = 1'b1;
            infl_q.push_back(r);
            pc_m = pc_m + 32'd4;
        end
        if (bt) begin
            fifo_q.delete();
            foreach (infl_q[i]) infl_q[i].live = 1'b0;
            pc_m = tgt;
        end
        @(negedge clk);
    endtask

    initial begin
        bit          vh[8];
        int          g0;
        logic [31:0] t;

        // Streaming with immediate grant and 1-cycle response
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            vh[i] = o_valid;
        end
        chk("t1_valid_c2", 32'(vh[1]), 32'h0);
        chk("t1_valid_c3", 32'(vh[2]), 32'h1);
        chk("t1_addr0", granted_q[0], 32'h0);
        chk("t1_addr1", granted_q[1], 32'h4);
        chk("t1_addr2", granted_q[2], 32'h8);
        chk("t1_pop0", popped_q[0], 32'h4);
        chk("t1_pop1", popped_q[1], 32'h8);
        chk("t1_pop2", popped_q[2], 32'hC);

        // Stall fills FIFO, then drain
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        g0 = granted_q.size();
        chk("t2_grants", 32'(g0), 32'd2);
        chk("t2_req_stalled", 32'(o_req), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("t2_drain0", popped_q[0], 32'h4);
        chk("t2_drain1", popped_q[1], 32'h8);

        // Redirect with two requests in flight
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        chk("t3_req_in_redirect", 32'(o_req), 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("t3_addr_target", o_addr, 32'h100);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("t3_req_target", 32'(o_req), 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t3_first_valid", 32'(o_valid), 32'h1);
        chk("t3_first_adder1", o_adder1, 32'h104);
        chk("t3_first_inst", o_inst, mem_fn(32'h100));

        // Redirect coinciding with rvalid and id_ld
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
        chk("t4_valid_before", 32'(o_valid), 32'h1);
`ifdef FETCH_PERF_EN
        chk("t4_squash2", perf_squash_cnt, 32'd2);
`endif
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t4_empty_after", 32'(o_valid), 32'h0);
        chk("t4_req_after", 32'(o_req), 32'h1);
        chk("t4_addr_after", o_addr, 32'h200);

        // PC wraparound
        do_reset();
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("t5_addr_top", o_addr, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("t5_addr_wrap", o_addr, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t5_valid", 32'(o_valid), 32'h1);
        chk("t5_adder1_wrap", o_adder1, 32'h0);

`ifdef FETCH_PERF_EN
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("t6_bubble3", perf_bubble_cnt, 32'd3);
`endif

        // Randomized traffic with one mid-run reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 19) == 0, t, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch-side producer for the IF/ID pipeline register.
- Generates the PC sequence and issues in-order requests to a variable-latency instruction memory (req/gnt, rvalid).
- Buffers returned instructions with their PC+4 in a small prefetch FIFO and presents {inst, adder1} to IF/ID.
- Handles taken-branch redirects by squashing buffered and in-flight fetches.

Parameters:
- DEPTH, 2, prefetch FIFO entries (power of two, >=2)
- MAX_OUTSTANDING, 2, max in-flight imem requests (>=1)
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (current PC)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  32  returned instruction
- branch_taken  in  1  redirect pulse from EX
- branch_target  in  32  redirect address
- id_ld  in  1  IF/ID load enable; consumer accepts the head entry
- if_valid  out  1  head entry valid
- inst  out  32  head instruction; 32'b0 when empty
- adder1  out  32  head PC+4; 32'b0 when empty

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty, outstanding=0, drop_cnt=0.
  - Outputs: imem_req=0, if_valid=0, inst=0, adder1=0. imem_addr=RESET_PC.
- Arithmetic: all PC math is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Issue:
  - imem_req=1 iff !branch_taken && outstanding<MAX_OUTSTANDING && fifo_count+(outstanding-drop_cnt)<DEPTH.
  - imem_addr=pc.
  - On req&&gnt: pc<=pc+4, outstanding+1.
  - The request stays asserted with a stable address until granted, unless a redirect occurs.
- Response (imem_rvalid=1): outstanding-1.
  - If drop_cnt>0: drop_cnt-1; data discarded.
  - Else: push {imem_rdata, resp_pc+4}; resp_pc<=resp_pc+4.
  - Space is guaranteed by the issue rule. A push into a full FIFO is an assertion failure.
- Output and pop:
  - Registered-head FIFO. if_valid = !empty; inst/adder1 come from the head.
  - Pop when id_ld && if_valid && !branch_taken.
  - Push and pop in the same cycle are allowed: count unchanged, including at full and at count=1.
  - A push into an empty FIFO is visible on outputs the next cycle (1-cycle response-to-IF/ID latency).
- Redirect (branch_taken=1), on the clock edge:
  - FIFO cleared; pc<=branch_target; resp_pc<=branch_target.
  - drop_cnt<=outstanding_next, where outstanding_next = outstanding - imem_rvalid. No grant is possible because req=0.
  - A response arriving in the redirect cycle is discarded.
  - Back-to-back redirects: the last one wins; drop_cnt recomputed each time.
  - The first fetch at the target issues on the cycle after the redirect.
- Stall: id_ld=0 holds the head. Fetch continues until the FIFO plus live in-flight requests reach DEPTH, then req=0.
- Reset mid-transaction: all state is cleared. The imem side must also be reset; late responses after reset are not supported.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_bubble_cnt[31:0] and perf_squash_cnt[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - perf_bubble_cnt increments each cycle id_ld=1 && if_valid=0.
  - perf_squash_cnt increments on a redirect by fifo_count plus live (non-dropped) outstanding requests.
- Undefined: the ports and counters are absent; there is no other behavioural difference.

Decomposition:
- Shared package if_pkg:
  - XLEN=32, NOP_INST=32'b0, PC_STEP=32'd4.
  - A fetch_entry_t struct {inst, adder1}.
- One natural sub-module: fetch_fifo (parameterized DEPTH, synchronous clear, simultaneous push/pop, full/empty/count). Reused by later prefetch work.

Test Plan:
- Reset release, gnt=1, 1-cycle rvalid, id_ld=1: addresses 0,4,8 issued; IF/ID sees inst with adder1=4,8,12; if_valid from cycle 3.
- id_ld=0 for 10 cycles with DEPTH=2: exactly 2 requests granted, then req=0; on id_ld=1, entries drain in order with correct adder1.
- 2 requests outstanding, branch_taken with target 32'h100: both late responses are dropped; next request addr=32'h100; first IF/ID entry has adder1=32'h104.
- Redirect in the same cycle as rvalid and id_ld: that response is discarded, no pop is counted, FIFO is empty next cycle, drop_cnt=outstanding-1.
- pc=32'hFFFF_FFFC fetch: adder1=0, next imem_addr=0.
- FETCH_PERF_EN: 3 empty-FIFO cycles with id_ld=1 give perf_bubble_cnt=3; a redirect with 1 buffered and 1 live in flight gives perf_squash_cnt=2.
